// File: rtl/memunit_if.sv
// memunit_if: shared EEI widths and the core-side memory bus between memunit and the MMIO controller.
package eei;
    localparam int XLEN = 64;
    localparam int MEMBUS_DATA_WIDTH = 64;
endpackage

interface Membus #(
    parameter int DW = eei::MEMBUS_DATA_WIDTH,
    parameter int AW = eei::XLEN
);
    logic            valid;
    logic            ready;
    logic [AW-1:0]   addr;
    logic            wen;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wmask;
    logic            rvalid;
    logic [DW-1:0]   rdata;
    modport master (output valid, addr, wen, wdata, wmask, input ready, rvalid, rdata);
    modport slave  (input valid, addr, wen, wdata, wmask, output ready, rvalid, rdata);
endinterface

// File: rtl/memunit.sv
// memunit: EX/MEM load/store unit; issues one aligned bus word request per access and extends load data.
module memunit #(
    parameter int XLEN = eei::XLEN,
    parameter int MEMBUS_DATA_WIDTH = eei::MEMBUS_DATA_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid,
    input  logic            is_new,
    input  logic            is_load,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wsrc,
    output logic [XLEN-1:0] rdata,
    output logic            stall,
    output logic            misaligned,
    Membus.master           membus
);
    localparam int MW = MEMBUS_DATA_WIDTH / 8;

    typedef enum logic [1:0] {INIT, WAIT_READY, WAIT_VALID} state_t;

    state_t                       state_q, state_d;
    logic [XLEN-1:0]              req_addr_q, req_addr_d;
    logic                         req_wen_q, req_wen_d;
    logic [2:0]                   req_funct3_q, req_funct3_d;
    logic [MEMBUS_DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
    logic [MW-1:0]                req_wmask_q, req_wmask_d;
    logic [XLEN-1:0]              rdata_q, rdata_d;
    logic                         memop, stall_c, req_active, load_done;
    logic [2:0]                   off;
    logic [MW-1:0]                wmask_c;
    logic [MEMBUS_DATA_WIDTH-1:0] word;
    logic [XLEN-1:0]              ld;

    assign off = addr[2:0];
    assign misaligned = valid && (is_load || is_store) &&
        ((funct3[1:0] == 2'b01 && addr[0]) ||
         (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) ||
         (funct3[1:0] == 2'b11 && addr[2:0] != 3'b000) ||
         funct3 == 3'b111 || (is_store && funct3[2]));
    assign memop = valid && (is_load || is_store) && !misaligned;

    assign wmask_c = funct3[1:0] == 2'b00 ? MW'(1) << off :
                     funct3[1:0] == 2'b01 ? MW'(3) << off :
                     funct3[1:0] == 2'b10 ? MW'(15) << off : {MW{1'b1}};

    // Bus returns the whole aligned word; bring the addressed bytes down to bit 0.
    assign word = membus.rdata >> {req_addr_q[2:0], 3'b000};
    assign ld = req_funct3_q == 3'b000 ? {{(XLEN-8){word[7]}}, word[7:0]} :
                req_funct3_q == 3'b001 ? {{(XLEN-16){word[15]}}, word[15:0]} :
                req_funct3_q == 3'b010 ? {{(XLEN-32){word[31]}}, word[31:0]} :
                req_funct3_q == 3'b100 ? XLEN'(word[7:0]) :
                req_funct3_q == 3'b101 ? XLEN'(word[15:0]) :
                req_funct3_q == 3'b110 ? XLEN'(word[31:0]) : word[XLEN-1:0];

    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        req_wen_d    = req_wen_q;
        req_funct3_d = req_funct3_q;
        req_wdata_d  = req_wdata_q;
        req_wmask_d  = req_wmask_q;
        rdata_d      = rdata_q;
        stall_c      = 1'b0;
        case (state_q)
            INIT: begin
                stall_c = memop && is_new;
                if (memop && is_new) begin
                    state_d      = WAIT_READY;
                    req_addr_d   = addr;
                    req_wen_d    = is_store;
                    req_funct3_d = funct3;
                    req_wdata_d  = MEMBUS_DATA_WIDTH'(wsrc) << {off, 3'b000};
                    req_wmask_d  = wmask_c;
                end
            end
            WAIT_READY: begin
                stall_c = 1'b1;
                if (membus.ready) state_d = WAIT_VALID;
            end
            WAIT_VALID: begin
                stall_c = !membus.rvalid;
                if (membus.rvalid) begin
                    state_d = INIT;
                    if (!req_wen_q) rdata_d = ld;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= INIT;
            req_addr_q   <= '0;
            req_wen_q    <= 1'b0;
            req_funct3_q <= '0;
            req_wdata_q  <= '0;
            req_wmask_q  <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            req_wen_q    <= req_wen_d;
            req_funct3_q <= req_funct3_d;
            req_wdata_q  <= req_wdata_d;
            req_wmask_q  <= req_wmask_d;
            rdata_q      <= rdata_d;
        end
    end

    assign req_active = state_q == WAIT_READY;
    assign load_done  = state_q == WAIT_VALID && membus.rvalid && !req_wen_q;
    // Reset must drop stall even while a fresh memop is still presented in INIT.
    assign stall = rst && stall_c;
    assign rdata = load_done ? ld : rdata_q;

    assign membus.valid = req_active;
    assign membus.addr  = req_active ? {req_addr_q[XLEN-1:3], 3'b000} : '0;
    assign membus.wen   = req_active && req_wen_q;
    assign membus.wdata = req_active ? req_wdata_q : '0;
    assign membus.wmask = req_active ? req_wmask_q : '0;
endmodule
